// File: rtl/tetris_render.sv
// rtl/tetris_render.sv - playfield/piece/border pixel source for the vga block
// Builds each 16-pixel group one group ahead of the beam and pulses frame_tick at vblank.

module tetris_render #(
   parameter int          H_VIS        = 800,
   parameter int          V_VIS        = 600,
   parameter int          H_TOTAL      = 1040,
   parameter int          V_TOTAL      = 666,
   parameter int          PF_X0        = 20,
   parameter int          PF_Y0        = 8,
   parameter int          PF_W         = 10,
   parameter int          PF_H         = 20,
   parameter logic [2:0]  BORDER_COLOR = 3'b111,
   parameter logic [2:0]  BG_COLOR     = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] cnt_X,
   input  logic [9:0]  cnt_Y,
   output logic [47:0] pixels,
   output logic        brd_rd_en,
   output logic [7:0]  brd_addr,
   input  logic [2:0]  brd_data,
   input  logic [15:0] piece_mask,
   input  logic [3:0]  piece_x,
   input  logic [4:0]  piece_y,
   input  logic [2:0]  piece_color,
   output logic        frame_tick
);

   typedef enum logic [2:0] {IDLE, ADDR, WAIT, BUILD, HOLD} state_t;

   localparam logic [6:0]        G_WRAP = 7'(H_TOTAL / 16);
   localparam logic signed [8:0] X0_S   = 9'(PF_X0);
   localparam logic signed [8:0] Y0_S   = 9'(PF_Y0);
   localparam logic signed [8:0] W_S    = 9'(PF_W);
   localparam logic signed [8:0] H_S    = 9'(PF_H);
   localparam logic signed [8:0] ZERO_S = 9'sd0;
   localparam logic signed [8:0] M1_S   = -9'sd1;
   localparam logic signed [8:0] THR_S  = 9'sd3;

   state_t state, state_nxt;

   logic [3:0]        nib;
   logic [6:0]        gx_raw, gx;
   logic [9:0]        ty;
   logic signed [8:0] c_t, r_t;
   logic              in_pf_t, vis_t, start, tick_now;
   logic [7:0]        addr_t;

   logic signed [8:0] c_q, r_q;
   logic [3:0]        ylo_q;
   logic              vis_q, inpf_q;
   logic [2:0]        cell_q;
   logic [47:0]       next_pix, pix_t;

   logic [15:0]       sh_mask;
   logic [3:0]        sh_x;
   logic [4:0]        sh_y;
   logic [2:0]        sh_col;

   logic signed [8:0] dx, dy;
   logic              covered, ring, occ;
   logic [2:0]        col;

   assign nib      = cnt_X[3:0];
   assign start    = (state == IDLE) && (nib == 4'd8);
   assign tick_now = (cnt_Y == 10'(V_VIS)) && (cnt_X == 11'd0);

   // Target group is one ahead of the beam; the last group of a line targets the next line.
   always_comb begin
      gx_raw = cnt_X[10:4] + 7'd1;
      gx     = gx_raw;
      ty     = cnt_Y;
      if (gx_raw == G_WRAP) begin
         gx = '0;
         ty = (cnt_Y == 10'(V_TOTAL - 1)) ? '0 : cnt_Y + 10'd1;
      end
      c_t     = $signed({2'b00, gx}) - X0_S;
      r_t     = $signed({3'b000, ty[9:4]}) - Y0_S;
      in_pf_t = (c_t >= ZERO_S) && (c_t < W_S) && (r_t >= ZERO_S) && (r_t < H_S);
      vis_t   = ({gx, 4'b0000} < 11'(H_VIS)) && (ty < 10'(V_VIS));
      addr_t  = 8'(r_t[7:0] * 8'(PF_W)) + c_t[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (nib == 4'd8) state_nxt = ADDR;
         ADDR:    state_nxt = WAIT;
         WAIT:    state_nxt = BUILD;
         BUILD:   state_nxt = HOLD;
         HOLD:    if (nib != 4'd12 && nib != 4'd13) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Colour selection for the latched target cell, first match wins.
   always_comb begin
      dx      = c_q - $signed({5'b00000, sh_x});
      dy      = r_q - $signed({4'b0000, sh_y});
      covered = inpf_q && (dx >= ZERO_S) && (dx <= THR_S) && (dy >= ZERO_S) && (dy <= THR_S)
                && sh_mask[{dy[1:0], dx[1:0]}];
      ring    = ((c_q == M1_S || c_q == W_S) && (r_q >= M1_S) && (r_q <= H_S)) ||
                ((r_q == M1_S || r_q == H_S) && (c_q >= M1_S) && (c_q <= W_S));
      occ     = 1'b0;
      col     = BG_COLOR;
      if (!vis_q) begin
         col = 3'b000;
      end else if (covered) begin
         col = sh_col;
         occ = 1'b1;
      end else if (inpf_q && cell_q != 3'b000) begin
         col = cell_q;
         occ = 1'b1;
      end else if (ring) begin
         col = BORDER_COLOR;
      end
      pix_t = '0;
      for (int k = 0; k < 16; k++)
         pix_t[3*k +: 3] = (occ && (k == 0 || ylo_q == 4'd0)) ? 3'b000 : col;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixels     <= '0;
         brd_rd_en  <= 1'b0;
         brd_addr   <= '0;
         frame_tick <= 1'b0;
         sh_mask    <= '0;
         sh_x       <= '0;
         sh_y       <= '0;
         sh_col     <= '0;
         c_q        <= '0;
         r_q        <= '0;
         ylo_q      <= '0;
         vis_q      <= 1'b0;
         inpf_q     <= 1'b0;
         cell_q     <= '0;
         next_pix   <= '0;
      end else begin
         brd_rd_en  <= 1'b0;
         frame_tick <= tick_now;
         if (tick_now) begin
            sh_mask <= piece_mask;
            sh_x    <= piece_x;
            sh_y    <= piece_y;
            sh_col  <= piece_color;
         end
         if (start) begin
            c_q       <= c_t;
            r_q       <= r_t;
            ylo_q     <= ty[3:0];
            vis_q     <= vis_t;
            inpf_q    <= in_pf_t;
            brd_rd_en <= in_pf_t;
            if (in_pf_t) brd_addr <= addr_t;
         end
         if (state == WAIT)  cell_q   <= brd_data;
         if (state == BUILD) next_pix <= pix_t;
         if (state == HOLD && nib == 4'd14) pixels <= next_pix;
      end
   end

endmodule

// File: tb/tb_tetris_render.sv
// tb/tb_tetris_render.sv - self-checking bench for tetris_render
// Directed vector table, reset/tick sequences, then random groups against a reference model.

module tb_tetris_render;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] cnt_X;
   logic [9:0]  cnt_Y;
   logic [47:0] pixels;
   logic        brd_rd_en;
   logic [7:0]  brd_addr;
   logic [2:0]  brd_data;
   logic [15:0] piece_mask;
   logic [3:0]  piece_x;
   logic [4:0]  piece_y;
   logic [2:0]  piece_color;
   logic        frame_tick;

   always #10 clk = ~clk;

   tetris_render dut (
      .clk(clk), .rst(rst), .cnt_X(cnt_X), .cnt_Y(cnt_Y), .pixels(pixels),
      .brd_rd_en(brd_rd_en), .brd_addr(brd_addr), .brd_data(brd_data),
      .piece_mask(piece_mask), .piece_x(piece_x), .piece_y(piece_y),
      .piece_color(piece_color), .frame_tick(frame_tick)
   );

   logic [2:0] mem [0:199];
   always @(posedge clk) if (brd_rd_en) brd_data <= mem[brd_addr];

   int          n_chk = 0;
   int          n_fail = 0;
   int          rd_cnt;
   logic [7:0]  rd_addr;
   logic [47:0] last_pix;
   logic [15:0] m_mask;
   int          m_x, m_y, m_col;

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] word_of(input int col, input bit first0);
      logic [47:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) w[3*k +: 3] = (first0 && k == 0) ? 3'b000 : 3'(col);
      return w;
   endfunction

   task automatic model(input int cx, input int cy, output logic [47:0] w, output int rd, output int addr);
      int gx, y, c, r, dx, dy, col;
      bit occ, inpf;
      gx = cx / 16 + 1;
      y  = cy;
      if (gx * 16 == 1040) begin
         gx = 0;
         y  = (cy + 1) % 666;
      end
      c    = gx - 20;
      r    = y / 16 - 8;
      inpf = (c >= 0 && c < 10 && r >= 0 && r < 20);
      rd   = inpf ? 1 : 0;
      addr = inpf ? r * 10 + c : 0;
      occ  = 0;
      col  = 0;
      if (gx * 16 >= 800 || y >= 600) col = 0;
      else if (inpf) begin
         dx = c - m_x;
         dy = r - m_y;
         if (dx >= 0 && dx < 4 && dy >= 0 && dy < 4 && m_mask[dy*4+dx]) begin
            col = m_col; occ = 1;
         end else if (mem[r*10+c] != 3'b000) begin
            col = int'(mem[r*10+c]); occ = 1;
         end
      end else if (c >= -1 && c <= 10 && r >= -1 && r <= 20) col = 7;
      w = '0;
      for (int k = 0; k < 16; k++)
         w[3*k +: 3] = (occ && (k == 0 || y % 16 == 0)) ? 3'b000 : 3'(col);
   endtask

   task automatic cyc(input int cx, input int cy);
      bit tick;
      @(negedge clk);
      cnt_X = 11'(cx);
      cnt_Y = 10'(cy);
      tick  = (cx == 0 && cy == 600 && rst === 1'b1);
      if (tick) begin
         m_mask = piece_mask; m_x = int'(piece_x); m_y = int'(piece_y); m_col = int'(piece_color);
      end
      @(posedge clk);
      #1;
      check("frame_tick", frame_tick, tick);
      if (brd_rd_en) begin
         rd_cnt++;
         rd_addr = brd_addr;
      end
   endtask

   task automatic run_group(input int g, input int cy, input logic [47:0] exp,
                            input int exp_rd, input int exp_addr, input string tag);
      rd_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(g * 16 + i, cy);
         if (i == 13) check({tag, " hold"}, pixels, last_pix);
         if (i == 14) check({tag, " pixels"}, pixels, exp);
      end
      check({tag, " rd_count"}, rd_cnt, exp_rd);
      if (exp_rd == 1) check({tag, " addr"}, rd_addr, exp_addr);
      last_pix = exp;
   endtask

   task automatic model_group(input int g, input int cy, input string tag);
      logic [47:0] w;
      int rd, addr;
      model(g * 16 + 8, cy, w, rd, addr);
      run_group(g, cy, w, rd, addr, tag);
   endtask

   typedef struct {
      int g; int cy; bit set_piece; bit tick;
      logic [15:0] mask; int px; int py; int pcol;
      int col; bit first0; int rd; int addr;
   } vec_t;

   vec_t vt[15];

   initial begin
      vt[0]  = '{19, 200, 0, 0, 16'h0000, 0, 0, 0, 2, 1, 1, 40};
      vt[1]  = '{19, 192, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 40};
      vt[2]  = '{21, 120, 0, 0, 16'h0000, 0, 0, 0, 7, 0, 0, 0};
      vt[3]  = '{18, 200, 0, 0, 16'h0000, 0, 0, 0, 7, 0, 0, 0};
      vt[4]  = '{29, 200, 0, 0, 16'h0000, 0, 0, 0, 7, 0, 0, 0};
      vt[5]  = '{30, 200, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{50, 200, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vt[7]  = '{19, 448, 0, 0, 16'h0000, 0, 0, 0, 7, 0, 0, 0};
      vt[8]  = '{28, 447, 0, 0, 16'h0000, 0, 0, 0, 5, 1, 1, 199};
      vt[9]  = '{19, 200, 1, 1, 16'h0001, 0, 4, 4, 4, 1, 1, 40};
      vt[10] = '{19, 200, 1, 0, 16'h0000, 3, 3, 1, 4, 1, 1, 40};
      vt[11] = '{19, 200, 0, 1, 16'h0000, 0, 0, 0, 2, 1, 1, 40};
      vt[12] = '{64, 599, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
      vt[13] = '{18, 127, 0, 0, 16'h0000, 0, 0, 0, 7, 0, 0, 0};
      vt[14] = '{60, 300, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};

      rst = 1'b0;
      cnt_X = '0; cnt_Y = '0; brd_data = '0;
      piece_mask = '0; piece_x = '0; piece_y = '0; piece_color = '0;
      m_mask = '0; m_x = 0; m_y = 0; m_col = 0;
      last_pix = '0;
      for (int i = 0; i < 200; i++) mem[i] = 3'b000;
      mem[40]  = 3'b010;
      mem[199] = 3'b101;

      repeat (3) @(posedge clk);
      #1;
      check("reset pixels", pixels, 48'h0);
      check("reset rd_en", brd_rd_en, 1'b0);
      check("reset addr", brd_addr, 8'h0);
      check("reset tick", frame_tick, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 15; v++) begin
         if (vt[v].set_piece) begin
            piece_mask  = vt[v].mask;
            piece_x     = 4'(vt[v].px);
            piece_y     = 5'(vt[v].py);
            piece_color = 3'(vt[v].pcol);
         end
         if (vt[v].tick) begin
            cyc(0, 600);
            cyc(1, 600);
         end
         run_group(vt[v].g, vt[v].cy, word_of(vt[v].col, vt[v].first0),
                   vt[v].rd, vt[v].addr, $sformatf("vec%0d", v));
      end

      // Asynchronous reset while a board read is in flight, released mid-group.
      model_group(19, 200, "pre_reset");
      rd_cnt = 0;
      for (int i = 0; i <= 8; i++) cyc(304 + i, 200);
      check("rd_en before reset", brd_rd_en, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async pixels", pixels, 48'h0);
      check("async rd_en", brd_rd_en, 1'b0);
      check("async tick", frame_tick, 1'b0);
      m_mask = '0; m_x = 0; m_y = 0; m_col = 0;
      cyc(313, 200);
      cyc(314, 200);
      rst = 1'b1;
      rd_cnt = 0;
      for (int i = 315; i < 320; i++) cyc(i, 200);
      check("post reset pixels held", pixels, 48'h0);
      check("post reset no read", rd_cnt, 0);
      last_pix = '0;
      model_group(19, 200, "after_reset");

      for (int i = 0; i < 200; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      for (int n = 0; n < 300; n++) begin
         int g, cy, sel;
         sel = $urandom_range(0, 9);
         if (sel < 3) begin
            piece_mask  = 16'($urandom);
            piece_x     = 4'($urandom_range(0, 9));
            piece_y     = 5'($urandom_range(0, 19));
            piece_color = 3'($urandom_range(1, 7));
         end
         if (sel == 0) begin
            cyc(0, 600);
            cyc(1, 600);
         end
         if (sel == 9) mem[$urandom_range(0, 199)] = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin
            g  = $urandom_range(16, 31);
            cy = $urandom_range(110, 465);
         end else begin
            g  = $urandom_range(0, 64);
            cy = $urandom_range(0, 665);
         end
         model_group(g, cy, $sformatf("rand%0d g%0d y%0d", n, g, cy));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
